memory_loader: RTL and testbench
================================

MEMORY_LOADER -- requirements
Module: memory_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of memory words (2..16).
REQ-002 Parameter WIDTH, default 8, data word width.
REQ-003 Parameter AW, default 4, address width; the block SHALL require 2^AW >= DEPTH.
REQ-004 Ports:
- iClk  in  1  single clock; all state changes on rising edge.
- iRst  in  1  reset, asynchronous, active-low.
- iSwitch  in  WIDTH  data word to store; quasi-static; sampled directly with no synchronizer.
- iWrite  in  1  raw write button, asynchronous.
- iClear  in  1  raw clear button, asynchronous.
- oWe  out  1  write strobe to the memory.
- oAddr  out  AW  write address.
- oData  out  WIDTH  write data.
- oBusy  out  1  high in any state other than IDLE.
- oFull  out  1  high while in FULL.
- oUnidades  out  4  BCD units digit of the stored-word count.
- oDecenas  out  4  BCD tens digit of the stored-word count.

Function
REQ-005 iWrite and iClear SHALL each pass through a 2-flop synchronizer, then a third flop for edge detection.
REQ-006 Edge detection SHALL produce a one-cycle pulse on each synchronized 0->1 transition; holding a button SHALL produce exactly one pulse.
REQ-007 States SHALL be IDLE, WRITE, FULL and CLEAR, held in a register count[AW:0] ranging 0..DEPTH.
REQ-008 In IDLE, a write pulse with no clear pulse SHALL capture iSwitch into a data register and move the FSM to WRITE.
REQ-009 In WRITE, oWe SHALL be 1 for exactly one cycle, with oAddr=count[AW-1:0] and oData equal to the captured word.
REQ-010 On leaving WRITE, count SHALL increment by 1; next state SHALL be FULL if the new count equals DEPTH, otherwise IDLE.
REQ-011 Latency: an iWrite rise that meets setup before edge k SHALL give oWe=1 in the cycle between edges k+3 and k+4.
REQ-012 In FULL, write pulses SHALL be ignored, with no strobe and no count change.
REQ-013 A clear pulse SHALL set a pending-clear flag, which SHALL hold until the CLEAR state is entered.
REQ-014 In IDLE or FULL with the pending-clear flag set, the next state SHALL be CLEAR.
- Clear SHALL take priority over a simultaneous write pulse; that write SHALL be dropped.
REQ-015 A clear pulse arriving in WRITE SHALL NOT abort the write; CLEAR SHALL be entered after the write completes and its count update is applied.
REQ-016 CLEAR SHALL write 0 to addresses 0..DEPTH-1 in ascending order, one per cycle, using oWe=1 for DEPTH consecutive cycles.
- On completion, count SHALL be 0 and the FSM SHALL return to IDLE.
REQ-017 Write and clear pulses arriving during CLEAR SHALL be dropped.
REQ-018 oDecenas SHALL be 1 and oUnidades SHALL be count-10 when count>=10; otherwise oDecenas=0 and oUnidades=count.
- Both SHALL be combinational from count.
REQ-019 oBusy and oFull SHALL be decoded directly from the state register; oWe, oAddr and oData SHALL be registered outputs.

Reset
REQ-020 Asserting iRst low SHALL immediately force all of the following, regardless of the clock:
- state=IDLE, count=0, pending-clear flag=0, all synchronizer and edge flops=0;
- oWe=0, oAddr=0, oData=0, oBusy=0, oFull=0, oUnidades=0, oDecenas=0.
REQ-021 Reset asserted mid-WRITE or mid-CLEAR SHALL abandon the operation; no strobe SHALL occur after iRst rises.

Structure
REQ-022 A shared package SHALL hold the state encoding (IDLE=0, WRITE=1, FULL=2, CLEAR=3) and the default DEPTH/WIDTH/AW constants.
REQ-023 One sub-module, btn_sync, SHALL implement the synchronizer and edge detector; it SHALL be instantiated twice, once for iWrite and once for iClear.
REQ-024 The memory array itself SHALL be outside this block.

Verification
REQ-025 Reset, then iSwitch=0x5A with one iWrite press -> one oWe pulse, oAddr=0, oData=0x5A, oUnidades=1, oDecenas=0, oBusy back to 0.
REQ-026 Hold iWrite high for 50 cycles -> exactly one oWe pulse, and count rises by exactly 1.
REQ-027 Sixteen presses with iSwitch=0x00..0x0F -> addresses 0..15 written in order, then oFull=1, oDecenas=1, oUnidades=6.
- A seventeenth press -> no oWe, count stays 16.
REQ-028 iClear press while FULL -> 16 consecutive oWe cycles with oData=0 and oAddr=0..15.
- Afterwards: oFull=0, oUnidades=0, oDecenas=0, state IDLE.
REQ-029 iWrite and iClear rise in the same cycle in IDLE -> only the clear sweep occurs, and count=0 at the end.
REQ-030 iRst driven low during the CLEAR sweep at address 7 -> all outputs 0 at once, and no further oWe after release.

Source files
------------

// File: rtl/memory_loader_pkg.sv
// Shared definitions for the memory loader: state encoding and default sizing.
// The state encoding is fixed so that firmware or debug taps reading the
// state register see IDLE=0, WRITE=1, FULL=2, CLEAR=3.
package memory_loader_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/btn_sync.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   btn   - raw asynchronous button level
//   pulse - one-cycle pulse per synchronized 0->1 transition
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    // A held button gives exactly one pulse: prev catches up one cycle later.
    assign pulse = sync & ~prev;

endmodule

// File: rtl/memory_loader.sv
// Memory loader: stores switch words into an external memory one button press
// at a time, and sweeps the memory to zero on a clear press. Shows the stored
// word count as two BCD digits.
//
// state  | meaning
// IDLE   | waiting for a write or clear request
// WRITE  | one write strobe of the captured word at address count
// FULL   | count == DEPTH, writes ignored until a clear
// CLEAR  | zeroing addresses 0..DEPTH-1, one per cycle
//
// Ports:
//   iClk, iRst          - clock, asynchronous active-low reset
//   iSwitch             - word to store (quasi-static, sampled directly)
//   iWrite, iClear      - raw asynchronous buttons
//   oWe, oAddr, oData   - registered memory write port
//   oBusy, oFull        - status decoded from the state register
//   oUnidades, oDecenas - BCD units/tens of the stored-word count
module memory_loader
    import memory_loader_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iSwitch,
    input  logic             iWrite,
    input  logic             iClear,
    output logic             oWe,
    output logic [AW-1:0]    oAddr,
    output logic [WIDTH-1:0] oData,
    output logic             oBusy,
    output logic             oFull,
    output logic [3:0]       oUnidades,
    output logic [3:0]       oDecenas
);

    if ((1 << AW) < DEPTH) begin : g_bad_aw
        $error("memory_loader: AW too small for DEPTH");
    end

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic wr_pulse;
    logic clr_pulse;

    btn_sync u_wr_sync (
        .clk   (iClk),
        .rst_n (iRst),
        .btn   (iWrite),
        .pulse (wr_pulse)
    );

    btn_sync u_clr_sync (
        .clk   (iClk),
        .rst_n (iRst),
        .btn   (iClear),
        .pulse (clr_pulse)
    );

    state_t           state, state_next;
    logic [AW:0]      count, count_next;
    logic             clr_pend, clr_pend_next;
    logic [AW-1:0]    clr_addr, clr_addr_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic             we_next;
    logic [AW-1:0]    addr_next;
    logic [WIDTH-1:0] wdata_next;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= ST_IDLE;
            count    <= '0;
            clr_pend <= 1'b0;
            clr_addr <= '0;
            data_q   <= '0;
            oWe      <= 1'b0;
            oAddr    <= '0;
            oData    <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            clr_pend <= clr_pend_next;
            clr_addr <= clr_addr_next;
            data_q   <= data_next;
            oWe      <= we_next;
            oAddr    <= addr_next;
            oData    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = count;
        clr_addr_next = clr_addr;
        data_next     = data_q;
        we_next       = 1'b0;
        addr_next     = '0;
        wdata_next    = '0;
        // Clear requests seen outside the sweep are remembered so a clear
        // arriving mid-write is serviced once the write has landed.
        clr_pend_next = clr_pend | (clr_pulse && (state != ST_CLEAR));

        case (state)
            ST_IDLE: begin
                if (clr_pend || clr_pulse) begin
                    state_next = ST_CLEAR;
                end else if (wr_pulse) begin
                    state_next = ST_WRITE;
                    data_next  = iSwitch;
                end
            end
            ST_WRITE: begin
                we_next    = 1'b1;
                addr_next  = count[AW-1:0];
                wdata_next = data_q;
                count_next = count + 1'b1;
                state_next = (count_next == FULL_CNT) ? ST_FULL : ST_IDLE;
            end
            ST_FULL: begin
                if (clr_pend || clr_pulse) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                we_next    = 1'b1;
                addr_next  = clr_addr;
                wdata_next = '0;
                if (clr_addr == LAST_ADDR) begin
                    state_next    = ST_IDLE;
                    count_next    = '0;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if ((state_next == ST_CLEAR) && (state != ST_CLEAR)) begin
            clr_pend_next = 1'b0;
            clr_addr_next = '0;
        end
    end

    assign oBusy = (state != ST_IDLE);
    assign oFull = (state == ST_FULL);

    // count never exceeds 16, so a 5-bit view is enough for the BCD split.
    logic [4:0] cnt5;
    assign cnt5 = 5'(count);

    always_comb begin
        oDecenas  = 4'd0;
        oUnidades = cnt5[3:0];
        if (cnt5 >= 5'd10) begin
            oDecenas  = 4'd1;
            oUnidades = 4'(cnt5 - 5'd10);
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
module tb_memory_loader;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic [7:0] iSwitch = 8'h00;
    logic       iWrite = 1'b0;
    logic       iClear = 1'b0;
    logic       oWe;
    logic [3:0] oAddr;
    logic [7:0] oData;
    logic       oBusy;
    logic       oFull;
    logic [3:0] oUnidades;
    logic [3:0] oDecenas;

    memory_loader dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iSwitch   (iSwitch),
        .iWrite    (iWrite),
        .iClear    (iClear),
        .oWe       (oWe),
        .oAddr     (oAddr),
        .oData     (oData),
        .oBusy     (oBusy),
        .oFull     (oFull),
        .oUnidades (oUnidades),
        .oDecenas  (oDecenas)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic [11:0] exp_q[$];

    // Monitor: every strobe must match the next expected {addr,data}.
    always @(negedge iClk) begin
        logic [11:0] exp_w;
        if (oWe) begin
            we_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got addr=%0d data=%02h required no strobe", oAddr, oData);
            end else begin
                exp_w = exp_q.pop_front();
                if ({oAddr, oData} !== exp_w) begin
                    errors++;
                    $display("FAIL strobe got addr=%0d data=%02h required addr=%0d data=%02h",
                             oAddr, oData, exp_w[11:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic press_write(input logic [7:0] d, input int hold);
        @(negedge iClk);
        iSwitch = d;
        iWrite  = 1'b1;
        repeat (hold) @(negedge iClk);
        iWrite = 1'b0;
        repeat (8) @(negedge iClk);
    endtask

    task automatic press_clear();
        @(negedge iClk);
        iClear = 1'b1;
        repeat (3) @(negedge iClk);
        iClear = 1'b0;
        repeat (24) @(negedge iClk);
    endtask

    task automatic push_sweep();
        for (int a = 0; a < 16; a++) exp_q.push_back({4'(a), 8'h00});
    endtask

    initial begin
        int w0;
        bit found;

        // Reset state
        #2;
        check("reset_outputs", {oWe, oAddr, oData, oBusy, oFull, oUnidades, oDecenas}, 32'd0);
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);

        // Single write
        w0 = we_count;
        exp_q.push_back({4'd0, 8'h5A});
        press_write(8'h5A, 3);
        check("single_we_count", we_count - w0, 1);
        check("single_units", oUnidades, 1);
        check("single_tens", oDecenas, 0);
        check("single_busy", oBusy, 0);

        // Long hold gives one write only
        w0 = we_count;
        exp_q.push_back({4'd1, 8'h33});
        press_write(8'h33, 50);
        check("hold_we_count", we_count - w0, 1);
        check("hold_units", oUnidades, 2);

        // Fresh start, fill to 16
        @(negedge iClk);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        check("rst_units", oUnidades, 0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({4'(i), 8'(i)});
            press_write(8'(i), 2);
        end
        check("fill_full", oFull, 1);
        check("fill_busy", oBusy, 1);
        check("fill_tens", oDecenas, 1);
        check("fill_units", oUnidades, 6);

        // Seventeenth press ignored
        w0 = we_count;
        press_write(8'hEE, 2);
        check("full_no_we", we_count - w0, 0);
        check("full_units", oUnidades, 6);
        check("full_stays", oFull, 1);

        // Clear from FULL
        w0 = we_count;
        push_sweep();
        press_clear();
        check("clr_we_count", we_count - w0, 16);
        check("clr_full", oFull, 0);
        check("clr_units", oUnidades, 0);
        check("clr_tens", oDecenas, 0);
        check("clr_busy", oBusy, 0);

        // Simultaneous write+clear from count 2: clear wins
        exp_q.push_back({4'd0, 8'h11});
        press_write(8'h11, 2);
        exp_q.push_back({4'd1, 8'h22});
        press_write(8'h22, 2);
        check("pre_sim_units", oUnidades, 2);
        w0 = we_count;
        push_sweep();
        @(negedge iClk);
        iSwitch = 8'h77;
        iWrite  = 1'b1;
        iClear  = 1'b1;
        repeat (3) @(negedge iClk);
        iWrite = 1'b0;
        iClear = 1'b0;
        repeat (24) @(negedge iClk);
        check("sim_we_count", we_count - w0, 16);
        check("sim_units", oUnidades, 0);
        check("sim_busy", oBusy, 0);

        // Clear arriving during WRITE: write completes, then sweep
        w0 = we_count;
        exp_q.push_back({4'd0, 8'hA5});
        push_sweep();
        @(negedge iClk);
        iSwitch = 8'hA5;
        iWrite  = 1'b1;
        @(negedge iClk);
        iClear = 1'b1;
        repeat (2) @(negedge iClk);
        iWrite = 1'b0;
        iClear = 1'b0;
        repeat (28) @(negedge iClk);
        check("wrclr_we_count", we_count - w0, 17);
        check("wrclr_units", oUnidades, 0);
        check("wrclr_busy", oBusy, 0);
        check("queue_drained", exp_q.size(), 0);

        // Reset during the sweep at address 7
        push_sweep();
        found = 1'b0;
        @(negedge iClk);
        iClear = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge iClk);
            if (c == 3) iClear = 1'b0;
            if (oWe && oAddr == 4'd7) found = 1'b1;
        end
        iClear = 1'b0;
        check("sweep_reached_7", found, 1);
        #1;
        iRst = 1'b0;
        #1;
        check("midrst_outputs", {oWe, oAddr, oData, oBusy, oFull, oUnidades, oDecenas}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge iClk);
        iRst = 1'b1;
        w0 = we_count;
        repeat (30) @(negedge iClk);
        check("post_rst_no_we", we_count - w0, 0);
        check("post_rst_busy", oBusy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
